// File: rtl/scan_digit_mux_if.sv
// rtl/scan_digit_mux_if.sv - digit inputs, colon tick and scanned display outputs of scan_digit_mux
interface scan_digit_mux_if;
    logic [3:0] MIN_ONES;
    logic [3:0] MIN_TENS;
    logic [3:0] HOUR_ONES;
    logic [3:0] HOUR_TENS;
    logic       SEC_TICK;
    logic [3:0] LED_COUNT;
    logic [3:0] DIGIT_SEL_N;
    logic       DP_N;

    modport master (
        output MIN_ONES, MIN_TENS, HOUR_ONES, HOUR_TENS, SEC_TICK,
        input  LED_COUNT, DIGIT_SEL_N, DP_N
    );

    modport slave (
        input  MIN_ONES, MIN_TENS, HOUR_ONES, HOUR_TENS, SEC_TICK,
        output LED_COUNT, DIGIT_SEL_N, DP_N
    );
endinterface

// File: rtl/scan_digit_mux.sv
// rtl/scan_digit_mux.sv - HH:MM digit scanner with per-slot blanking and frame snapshot
// Optional: LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module scan_digit_mux #(
    parameter logic [15:0] SCAN_DIV     = 16'd1000,
    parameter logic [15:0] BLANK_CYCLES = 16'd50
) (
    input  logic             CLK,
    input  logic             RESET,
    scan_digit_mux_if.slave  bus
);

    logic [15:0]      slot_cnt_q, slot_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  snap_q, snap_d;
    logic             colon_on_q, colon_on_d;

    logic             frame_start;
    logic             active;

    assign frame_start = (slot_cnt_q == 16'd0) && (idx_q == 2'd0);
    assign active      = (slot_cnt_q >= BLANK_CYCLES);

    always_comb begin
        slot_cnt_d = slot_cnt_q + 16'd1;
        idx_d      = idx_q;
        snap_d     = snap_q;
        colon_on_d = colon_on_q ^ bus.SEC_TICK;
        if (slot_cnt_q == SCAN_DIV - 16'd1) begin
            slot_cnt_d = 16'd0;
            idx_d      = idx_q + 2'd1;
        end
        // Whole-frame capture keeps all four digits from one instant.
        if (frame_start) begin
            snap_d[0] = bus.MIN_ONES;
            snap_d[1] = bus.MIN_TENS;
            snap_d[2] = bus.HOUR_ONES;
            snap_d[3] = bus.HOUR_TENS;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            slot_cnt_q <= 16'd0;
            idx_q      <= 2'd0;
            snap_q     <= {4{4'hF}};
            colon_on_q <= 1'b1;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            colon_on_q <= colon_on_d;
        end
    end

    always_comb begin
        bus.DIGIT_SEL_N = 4'b1111;
        bus.LED_COUNT   = 4'hF;
        bus.DP_N        = 1'b1;
        if (active) begin
            bus.DIGIT_SEL_N = ~(4'b0001 << idx_q);
            bus.LED_COUNT   = snap_q[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
            if ((idx_q == 2'd3) && (snap_q[3] == 4'h0)) begin
                bus.LED_COUNT = 4'hF;
            end
`else
`endif
            bus.DP_N = ~((idx_q == 2'd2) && colon_on_q);
        end
    end

endmodule
